matrix_window_ctrl: RTL and testbench

//  Sequencer for the 3x3 line-buffer window generator in the DVP video-processing (VP) chain.
//  - Tracks frame, line and pixel position from the raw per_vs/per_de stream.
//  - Drives the line-shift-RAM shift enable and the window-register read enable.
//  - Flags which window outputs hold a complete 3x3 neighbourhood, and gives their centre coordinates.
//  - Latches the runtime resolution at frame start and reports line-length and line-count errors.

---
 rtl/vp_pkg.sv | 31 +++
 rtl/vp_edge_det.sv | 33 +++
 rtl/matrix_window_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_matrix_window_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// -----------------------------------------------------------------------------
// vp_pkg
// Shared types and constants for the VP-chain 3x3 window sequencer.
//   - vp_state_e : sequencer state encoding (IDLE/ARMED/FILL/RUN)
//   - WIN_LAT    : clocks from line-RAM shift to window-register update
//   - WIN_BORDER : rows/cols that must be seen before a window is complete
//   - calc_cw / calc_rw : counter widths derived from the maximum resolution
// -----------------------------------------------------------------------------
package vp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } vp_state_e;

  localparam int WIN_LAT    = 2;
  localparam int WIN_BORDER = 2;

  // Column counter width for a given maximum active width.
  function automatic int calc_cw(input int max_hdisp);
    return (max_hdisp > 1) ? $clog2(max_hdisp) : 1;
  endfunction

  // Row counter width for a given maximum active height.
  function automatic int calc_rw(input int max_vdisp);
    return (max_vdisp > 1) ? $clog2(max_vdisp) : 1;
  endfunction

endpackage

// File: rtl/vp_edge_det.sv
// -----------------------------------------------------------------------------
// vp_edge_det
// 1-bit rise/fall detector against a 1-clk registered copy of the input.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (clears the registered copy)
//   sig_i  : input level
//   rise_o : sig_i is 1 and was 0 last clk
//   fall_o : sig_i is 0 and was 1 last clk
// -----------------------------------------------------------------------------
module vp_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Previous-clk copy of the input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/matrix_window_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_window_ctrl
// Sequencer for the 3x3 line-buffer window generator. Tracks frame/line/pixel
// position from per_vs/per_de, drives the line-RAM shift and window-register
// enables, flags complete windows with their centre coordinates and reports
// line-length / line-count errors.
// Ports:
//   clk, rst                 : pixel clock, synchronous active-high reset
//   cfg_en                   : enable; 0 returns to IDLE at a frame boundary
//   cfg_hdisp, cfg_vdisp     : resolution, latched on accepted per_vs rise
//   per_vs, per_de           : raw frame-valid level and pixel-valid
//   shift_en                 : line-RAM shift enable (per_de while busy)
//   read_de, win_de          : shift_en delayed by 1 and 2 clks
//   win_valid, win_x, win_y  : complete window flag and its centre position
//   frame_start, frame_done  : 1-clk frame boundary pulses
//   line_err, ovf_err        : 1-clk error pulses
//   busy                     : state is FILL or RUN
// -----------------------------------------------------------------------------
module matrix_window_ctrl
  import vp_pkg::*;
#(
  parameter int MAX_HDISP = 1280,
  parameter int MAX_VDISP = 720,
  parameter int CW        = calc_cw(MAX_HDISP),
  parameter int RW        = calc_rw(MAX_VDISP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic [CW-1:0] cfg_hdisp,
  input  logic [RW-1:0] cfg_vdisp,
  input  logic          per_vs,
  input  logic          per_de,
  output logic          shift_en,
  output logic          read_de,
  output logic          win_de,
  output logic          win_valid,
  output logic [CW-1:0] win_x,
  output logic [RW-1:0] win_y,
  output logic          frame_start,
  output logic          frame_done,
  output logic          line_err,
  output logic          ovf_err,
  output logic          busy
);

  localparam logic [CW-1:0] COL_MAX    = CW'(MAX_HDISP - 1);
  localparam logic [RW-1:0] ROW_MAX    = RW'(MAX_VDISP - 1);
  localparam logic [CW-1:0] COL_ONE    = CW'(1);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);
  localparam logic [CW-1:0] COL_BORDER = CW'(WIN_BORDER);
  localparam logic [RW-1:0] ROW_BORDER = RW'(WIN_BORDER);
  localparam logic [CW-1:0] HDISP_MIN  = CW'(WIN_BORDER + 1);

  vp_state_e     state_q;
  logic          busy_q;
  logic          frame_start_q;
  logic          frame_done_q;
  logic          line_err_q;
  logic          ovf_err_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] hdisp_q;
  logic [RW-1:0] vdisp_q;

  logic [WIN_LAT-1:0] de_pipe_q;
  logic [CW-1:0]      tag_col_q;
  logic [RW-1:0]      tag_row_q;
  logic               win_valid_q;
  logic [CW-1:0]      win_x_q;
  logic [RW-1:0]      win_y_q;

  logic          vs_rise;
  logic          vs_fall;
  logic          de_rise;
  logic          de_fall;
  logic [CW-1:0] col_inc;
  logic [RW-1:0] row_inc;
  logic          win_full;

  vp_edge_det u_vs_det (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (per_vs),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  vp_edge_det u_de_det (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (per_de),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  // busy_q tracks FILL/RUN exactly, so it doubles as the shift gate.
  assign shift_en = per_de & busy_q;

  // Saturating counter increments and the stage-1 window-complete test.
  always_comb begin
    col_inc  = col_q;
    row_inc  = row_q;
    win_full = 1'b0;
    if (col_q != COL_MAX) begin
      col_inc = col_q + COL_ONE;
    end else begin
      col_inc = col_q;
    end
    if (row_q != ROW_MAX) begin
      row_inc = row_q + ROW_ONE;
    end else begin
      row_inc = row_q;
    end
    // Overflow lines fail the row<vdisp test; a narrow cfg never yields windows.
    if ((tag_col_q >= COL_BORDER) && (tag_row_q >= ROW_BORDER) &&
        (tag_row_q < vdisp_q) && (hdisp_q >= HDISP_MIN)) begin
      win_full = 1'b1;
    end else begin
      win_full = 1'b0;
    end
  end

  // Frame/line sequencer: state, position counters, latched cfg, event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      ovf_err_q     <= 1'b0;
      col_q         <= {CW{1'b0}};
      row_q         <= {RW{1'b0}};
      hdisp_q       <= {CW{1'b0}};
      vdisp_q       <= {RW{1'b0}};
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      ovf_err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (cfg_en) begin
            state_q <= ARMED;
          end else begin
            state_q <= IDLE;
          end
        end
        ARMED: begin
          if (!cfg_en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (vs_rise) begin
            state_q       <= FILL;
            busy_q        <= 1'b1;
            frame_start_q <= 1'b1;
            hdisp_q       <= cfg_hdisp;
            vdisp_q       <= cfg_vdisp;
            col_q         <= {CW{1'b0}};
            row_q         <= {RW{1'b0}};
          end else begin
            state_q <= ARMED;
            busy_q  <= 1'b0;
          end
        end
        FILL, RUN: begin
          // Frame end wins over a line end in the same clk.
          if (vs_fall) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= cfg_en ? ARMED : IDLE;
          end else begin
            busy_q <= 1'b1;
            if (de_fall) begin
              col_q      <= {CW{1'b0}};
              row_q      <= row_inc;
              line_err_q <= (col_q != hdisp_q);
              // Line 1 ending means the two border rows are in the line RAM.
              if (row_q >= ROW_ONE) begin
                state_q <= RUN;
              end else begin
                state_q <= state_q;
              end
            end else if (per_de) begin
              col_q     <= col_inc;
              ovf_err_q <= de_rise && (row_q >= vdisp_q);
            end else begin
              col_q <= col_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Enable delay line and position tags, aligned so win_* update with win_de.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_pipe_q   <= {WIN_LAT{1'b0}};
      tag_col_q   <= {CW{1'b0}};
      tag_row_q   <= {RW{1'b0}};
      win_valid_q <= 1'b0;
      win_x_q     <= {CW{1'b0}};
      win_y_q     <= {RW{1'b0}};
    end else begin
      de_pipe_q   <= {de_pipe_q[WIN_LAT-2:0], shift_en};
      win_valid_q <= de_pipe_q[0] & win_full;
      if (shift_en) begin
        tag_col_q <= col_q;
        tag_row_q <= row_q;
      end else begin
        tag_col_q <= tag_col_q;
        tag_row_q <= tag_row_q;
      end
      // Centre of the window is one column/row behind the newest pixel.
      if (de_pipe_q[0]) begin
        win_x_q <= tag_col_q - COL_ONE;
        win_y_q <= tag_row_q - ROW_ONE;
      end else begin
        win_x_q <= win_x_q;
        win_y_q <= win_y_q;
      end
    end
  end

  assign read_de     = de_pipe_q[0];
  assign win_de      = de_pipe_q[WIN_LAT-1];
  assign win_valid   = win_valid_q;
  assign win_x       = win_x_q;
  assign win_y       = win_y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_err    = line_err_q;
  assign ovf_err     = ovf_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matrix_window_ctrl
// Directed bench for matrix_window_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A negedge monitor
// keeps running event counts; each test snapshots them and checks deltas.
// -----------------------------------------------------------------------------
module tb_matrix_window_ctrl;

  localparam int CW = 11;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic [CW-1:0] cfg_hdisp;
  logic [RW-1:0] cfg_vdisp;
  logic          per_vs;
  logic          per_de;
  logic          shift_en;
  logic          read_de;
  logic          win_de;
  logic          win_valid;
  logic [CW-1:0] win_x;
  logic [RW-1:0] win_y;
  logic          frame_start;
  logic          frame_done;
  logic          line_err;
  logic          ovf_err;
  logic          busy;

  int n_chk = 0;
  int n_bad = 0;

  int n_fs = 0, n_fd = 0, n_le = 0, n_ov = 0, n_win = 0, n_sh = 0, n_busy = 0;
  int s_fs, s_fd, s_le, s_ov, s_win, s_sh, s_busy;
  int mark_win = 0;
  int first_x = 0, first_y = 0, last_x = 0, last_y = 0;

  always #5 clk = ~clk;

  matrix_window_ctrl #(.MAX_HDISP(1280), .MAX_VDISP(720)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .cfg_hdisp   (cfg_hdisp),
    .cfg_vdisp   (cfg_vdisp),
    .per_vs      (per_vs),
    .per_de      (per_de),
    .shift_en    (shift_en),
    .read_de     (read_de),
    .win_de      (win_de),
    .win_valid   (win_valid),
    .win_x       (win_x),
    .win_y       (win_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .ovf_err     (ovf_err),
    .busy        (busy)
  );

  // Running event counts and first/last window coordinates.
  always @(negedge clk) begin
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
    if (line_err)    n_le++;
    if (ovf_err)     n_ov++;
    if (shift_en)    n_sh++;
    if (busy)        n_busy++;
    if (win_valid) begin
      if (n_win == mark_win) begin
        first_x = int'(win_x);
        first_y = int'(win_y);
      end
      last_x = int'(win_x);
      last_y = int'(win_y);
      n_win++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_fs = n_fs; s_fd = n_fd; s_le = n_le; s_ov = n_ov;
    s_win = n_win; s_sh = n_sh; s_busy = n_busy;
    mark_win = n_win;
  endtask

  task automatic send_line(input int npx, input int gap);
    for (int i = 0; i < npx; i++) begin
      per_de = 1'b1;
      tick();
    end
    per_de = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic frame_open();
    per_vs = 1'b1;
    tick();
    tick();
  endtask

  task automatic frame_close();
    per_vs = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic send_frame(input int nlines, input int npx);
    frame_open();
    for (int l = 0; l < nlines; l++) send_line(npx, 4);
    frame_close();
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; per_vs = 1'b0; per_de = 1'b0;
    cfg_hdisp = 11'd8; cfg_vdisp = 10'd6;
    tick(); tick(); tick();
    @(negedge clk);
    check_eq("rst_flags", {23'd0, shift_en, read_de, win_de, win_valid, frame_start,
                           frame_done, line_err, ovf_err, busy}, 32'd0);
    check_eq("rst_x", {21'd0, win_x}, 32'd0);
    check_eq("rst_y", {22'd0, win_y}, 32'd0);

    tick();
    rst = 1'b0; cfg_en = 1'b1;
    tick(); tick();

    // T1: 8x6 frame -> 6x4 complete windows, centres (1,1)..(6,4)
    snap();
    send_frame(6, 8);
    check_eq("t1_fs",    n_fs - s_fs, 32'd1);
    check_eq("t1_fd",    n_fd - s_fd, 32'd1);
    check_eq("t1_win",   n_win - s_win, 32'd24);
    check_eq("t1_fx",    first_x, 32'd1);
    check_eq("t1_fy",    first_y, 32'd1);
    check_eq("t1_lx",    last_x, 32'd6);
    check_eq("t1_ly",    last_y, 32'd4);
    check_eq("t1_le",    n_le - s_le, 32'd0);
    check_eq("t1_ov",    n_ov - s_ov, 32'd0);
    check_eq("t1_sh",    n_sh - s_sh, 32'd48);
    @(negedge clk);
    check_eq("t1_busy",  busy, 32'd0);

    // T2: exact latency of the first complete window (row 2, col 2)
    tick();
    snap();
    per_vs = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t2_fs_pulse", frame_start, 32'd1);
    check_eq("t2_busy_on",  busy, 32'd1);
    tick();
    @(negedge clk);
    check_eq("t2_fs_end",   frame_start, 32'd0);
    send_line(8, 4);
    send_line(8, 4);
    per_de = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_eq("t2_n_shift",  shift_en, 32'd1);
    check_eq("t2_n_valid",  win_valid, 32'd0);
    tick();
    @(negedge clk);
    check_eq("t2_n1_read",  read_de, 32'd1);
    check_eq("t2_n1_valid", win_valid, 32'd0);
    tick();
    @(negedge clk);
    check_eq("t2_n2_wde",   win_de, 32'd1);
    check_eq("t2_n2_valid", win_valid, 32'd1);
    check_eq("t2_n2_x",     {21'd0, win_x}, 32'd1);
    check_eq("t2_n2_y",     {22'd0, win_y}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    per_de = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int l = 0; l < 3; l++) send_line(8, 4);
    frame_close();
    check_eq("t2_win", n_win - s_win, 32'd24);

    // T3: line 3 short by one pixel -> one line_err, rows keep counting
    snap();
    frame_open();
    for (int l = 0; l < 6; l++) send_line((l == 3) ? 7 : 8, 4);
    frame_close();
    check_eq("t3_le",  n_le - s_le, 32'd1);
    check_eq("t3_win", n_win - s_win, 32'd23);
    check_eq("t3_ly",  last_y, 32'd4);
    check_eq("t3_fd",  n_fd - s_fd, 32'd1);

    // T4: 8 lines on a 6-line cfg; mid-frame cfg change must not matter
    snap();
    frame_open();
    cfg_vdisp = 10'd3;
    for (int l = 0; l < 8; l++) send_line(8, 4);
    frame_close();
    cfg_vdisp = 10'd6;
    check_eq("t4_ov",  n_ov - s_ov, 32'd2);
    check_eq("t4_win", n_win - s_win, 32'd24);
    check_eq("t4_ly",  last_y, 32'd4);
    check_eq("t4_sh",  n_sh - s_sh, 32'd64);
    check_eq("t4_le",  n_le - s_le, 32'd0);

    // T5: 1-clk reset inside row 3; rest of the frame is ignored
    frame_open();
    for (int l = 0; l < 3; l++) send_line(8, 4);
    per_de = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_flags", {23'd0, shift_en, read_de, win_de, win_valid, frame_start,
                          frame_done, line_err, ovf_err, busy}, 32'd0);
    snap();
    tick(); tick(); tick();
    per_de = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    send_line(8, 4);
    send_line(8, 4);
    frame_close();
    check_eq("t5_sh",  n_sh - s_sh, 32'd0);
    check_eq("t5_win", n_win - s_win, 32'd0);
    check_eq("t5_fd",  n_fd - s_fd, 32'd0);
    snap();
    send_frame(6, 8);
    check_eq("t5_new_fs",  n_fs - s_fs, 32'd1);
    check_eq("t5_new_win", n_win - s_win, 32'd24);

    // T6: cfg_en dropped mid-frame -> frame completes, then IDLE
    snap();
    frame_open();
    for (int l = 0; l < 3; l++) send_line(8, 4);
    cfg_en = 1'b0;
    for (int l = 0; l < 3; l++) send_line(8, 4);
    frame_close();
    check_eq("t6_fd",  n_fd - s_fd, 32'd1);
    check_eq("t6_win", n_win - s_win, 32'd24);
    snap();
    send_frame(6, 8);
    check_eq("t6_ign_fs",   n_fs - s_fs, 32'd0);
    check_eq("t6_ign_sh",   n_sh - s_sh, 32'd0);
    check_eq("t6_ign_busy", n_busy - s_busy, 32'd0);
    cfg_en = 1'b1;
    tick(); tick();

    // T7: degenerate width -> no windows, every 8-px line flags line_err
    cfg_hdisp = 11'd2;
    snap();
    send_frame(6, 8);
    cfg_hdisp = 11'd8;
    check_eq("t7_fs",  n_fs - s_fs, 32'd1);
    check_eq("t7_win", n_win - s_win, 32'd0);
    check_eq("t7_le",  n_le - s_le, 32'd6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
